// File: rtl/adc_frame_sequencer_pkg.sv
// Shared definitions for the ADC frame sequencer: FSM encoding, command word
// layout and conversion code width.
package adc_frame_sequencer_pkg;

    localparam int CODE_W         = 12;
    localparam int CHAN_W         = 3;
    localparam int CMD_W          = 16;
    localparam int CMD_PREFIX_W   = 4;
    localparam int CMD_PREFIX_LSB = 12;
    localparam int CMD_CHAN_LSB   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_DONE      = 3'd4
    } seq_state_e;

    // Command word: {prefix, 1'b0, chan[2:0], 8'h00}
    function automatic logic [CMD_W-1:0] build_cmd(input logic [CMD_PREFIX_W-1:0] prefix,
                                                   input logic [CHAN_W-1:0]       chan);
        logic [CMD_W-1:0] word;
        word = 16'h0000;
        word[CMD_PREFIX_LSB +: CMD_PREFIX_W] = prefix;
        word[CMD_CHAN_LSB +: CHAN_W]         = chan;
        return word;
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Two-entry sample FIFO. The head entry lives in dedicated flops so the
// downstream outputs come straight from registers. A push into a full FIFO
// succeeds only when a pop happens in the same cycle; otherwise drop_o pulses.
module adc_sample_fifo
    import adc_frame_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [CODE_W-1:0] push_data_i,
    input  logic [CHAN_W-1:0] push_chan_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [CODE_W-1:0] data_o,
    output logic [CHAN_W-1:0] chan_o,
    output logic              drop_o
);

    logic [1:0]        count_q, count_d;
    logic [CODE_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [CHAN_W-1:0] head_chan_q, head_chan_d, tail_chan_q, tail_chan_d;
    logic              pop_s;
    logic              push_ok_s;

    // Push/pop arbitration and next-state of the two storage slots
    always_comb begin
        pop_s       = (count_q != 2'd0) && ready_i;
        push_ok_s   = push_i && ((count_q != 2'd2) || pop_s);
        drop_o      = push_i && !push_ok_s;
        count_d     = count_q;
        head_data_d = head_data_q;
        head_chan_d = head_chan_q;
        tail_data_d = tail_data_q;
        tail_chan_d = tail_chan_q;
        case ({push_ok_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_data_d = push_data_i;
                    head_chan_d = push_chan_i;
                end else begin
                    tail_data_d = push_data_i;
                    tail_chan_d = push_chan_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_data_d = tail_data_q;
                head_chan_d = tail_chan_q;
                count_d     = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_data_d = push_data_i;
                    head_chan_d = push_chan_i;
                end else begin
                    head_data_d = tail_data_q;
                    head_chan_d = tail_chan_q;
                    tail_data_d = push_data_i;
                    tail_chan_d = push_chan_i;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Storage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= 2'd0;
            head_data_q <= 12'h000;
            head_chan_q <= 3'd0;
            tail_data_q <= 12'h000;
            tail_chan_q <= 3'd0;
        end else begin
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_chan_q <= head_chan_d;
            tail_data_q <= tail_data_d;
            tail_chan_q <= tail_chan_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_data_q;
    assign chan_o  = head_chan_q;

endmodule

// File: rtl/adc_frame_sequencer.sv
// Periodic ADC frame sequencer. Every FRAME_DIV cycles (while enabled and idle)
// it issues N_CHAN+1 command words to an SPI master; the ADC answers one
// transfer late, so the first reply is discarded and the trailing dummy
// transfer collects the last channel's result. Results go through a 2-entry
// FIFO to a valid/ready sink; a result that cannot be buffered sets overrun_o.
module adc_frame_sequencer
    import adc_frame_sequencer_pkg::*;
#(
    parameter int                      N_CHAN     = 4,
    parameter int                      FRAME_DIV  = 250,
    parameter logic [CMD_PREFIX_W-1:0] CMD_PREFIX = 4'h1
) (
    input  logic              clk_1Mhz,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              di_req_i,
    output logic [CMD_W-1:0]  di_o,
    output logic              wren_o,
    input  logic              wr_ack_i,
    input  logic              do_valid_i,
    input  logic [CMD_W-1:0]  do_i,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic [CODE_W-1:0] sample_data_o,
    output logic [CHAN_W-1:0] sample_chan_o,
    output logic              frame_done_o,
    output logic              overrun_o
);

    localparam int               DIV_W     = $clog2(FRAME_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAME_DIV - 1);
    localparam logic [3:0]       LAST_XFER = 4'(N_CHAN);

    seq_state_e        state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [3:0]        xfer_q, xfer_d;
    logic [CMD_W-1:0]  di_q, di_d;
    logic              wren_q, wren_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;
    logic              tick_s;
    logic [CHAN_W-1:0] cmd_chan_s;
    logic [CHAN_W-1:0] res_chan_s;
    logic              push_s;
    logic              drop_s;
    logic              unused_do_chan_s;

    // The channel tag returned by the ADC is not trusted; the sequencer's own
    // transfer counter labels every sample.
    assign unused_do_chan_s = ^do_i[15:12];

    // Free-running frame divider and channel/result bookkeeping
    always_comb begin
        div_cnt_d  = (div_cnt_q == DIV_LAST) ? DIV_W'(0) : div_cnt_q + DIV_W'(1);
        tick_s     = (div_cnt_q == DIV_W'(0));
        cmd_chan_s = (xfer_q == LAST_XFER) ? 3'd0 : xfer_q[2:0];
        res_chan_s = 3'(xfer_q - 4'd1);
        push_s     = (state_q == ST_WAIT_DATA) && do_valid_i && (xfer_q != 4'd0);
        overrun_d  = overrun_q | drop_s;
    end

    // Sequencer FSM: next state, transfer counter and SPI write interface
    always_comb begin
        state_d      = state_q;
        xfer_d       = xfer_q;
        di_d         = di_q;
        wren_d       = wren_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_s && enable_i) begin
                    state_d = ST_LOAD;
                    xfer_d  = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (di_req_i) begin
                    di_d    = build_cmd(CMD_PREFIX, cmd_chan_s);
                    wren_d  = 1'b1;
                    state_d = ST_WAIT_ACK;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WAIT_ACK: begin
                if (wr_ack_i) begin
                    wren_d  = 1'b0;
                    state_d = ST_WAIT_DATA;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DATA: begin
                if (do_valid_i) begin
                    if (xfer_q == LAST_XFER) begin
                        state_d = ST_DONE;
                    end else begin
                        xfer_d  = xfer_q + 4'd1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
                xfer_d       = 4'd0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                wren_d  = 1'b0;
                xfer_d  = 4'd0;
            end
        endcase
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk_1Mhz) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= DIV_W'(0);
            xfer_q       <= 4'd0;
            di_q         <= 16'h0000;
            wren_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            xfer_q       <= xfer_d;
            di_q         <= di_d;
            wren_q       <= wren_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    adc_sample_fifo u_fifo (
        .clk         (clk_1Mhz),
        .reset       (reset),
        .push_i      (push_s),
        .push_data_i (do_i[CODE_W-1:0]),
        .push_chan_i (res_chan_s),
        .ready_i     (sample_ready_i),
        .valid_o     (sample_valid_o),
        .data_o      (sample_data_o),
        .chan_o      (sample_chan_o),
        .drop_o      (drop_s)
    );

    assign di_o         = di_q;
    assign wren_o       = wren_q;
    assign frame_done_o = frame_done_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Bench for adc_frame_sequencer: an SPI/ADC responder, a sink and a bounded
// queue model of the sample buffer, with one task per scenario.
module tb_adc_frame_sequencer;

    localparam int N_CHAN = 4;

    logic        clk_1Mhz = 1'b0;
    logic        reset;
    logic        enable_i;
    logic        di_req_i;
    logic [15:0] di_o;
    logic        wren_o;
    logic        wr_ack_i;
    logic        do_valid_i;
    logic [15:0] do_i;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic [11:0] sample_data_o;
    logic [2:0]  sample_chan_o;
    logic        frame_done_o;
    logic        overrun_o;

    always #5 clk_1Mhz = ~clk_1Mhz;

    adc_frame_sequencer #(.N_CHAN(N_CHAN), .FRAME_DIV(250), .CMD_PREFIX(4'h1)) dut (
        .clk_1Mhz       (clk_1Mhz),
        .reset          (reset),
        .enable_i       (enable_i),
        .di_req_i       (di_req_i),
        .di_o           (di_o),
        .wren_o         (wren_o),
        .wr_ack_i       (wr_ack_i),
        .do_valid_i     (do_valid_i),
        .do_i           (do_i),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_data_o  (sample_data_o),
        .sample_chan_o  (sample_chan_o),
        .frame_done_o   (frame_done_o),
        .overrun_o      (overrun_o)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    int ready_mode  = 0;   // 0: always ready, 1: never ready, 2: random
    int req_mode    = 0;   // 0: di_req always high, 1: random
    int rand_mode   = 0;   // random delays and codes in the responder
    int ack_dly_fix = 2;
    int data_dly_fix = 1;

    logic [15:0] cmd_q[$];      // commands accepted by the responder
    bit          hold_q[$];     // 1 if wren/di stayed stable until ack
    logic [14:0] got_q[$];      // {chan, code} popped by the sink
    logic [14:0] exp_pop_q[$];  // {chan, code} the buffer model expects to be popped
    logic [14:0] model_q[$];    // buffer model contents
    bit          exp_ovr;
    int          done_cnt;
    int          valid_err;
    logic        push_flag;
    logic [14:0] push_item;

    // Sink-ready and di_req drivers
    initial begin : knob_driver
        sample_ready_i = 1'b1;
        di_req_i       = 1'b1;
        forever begin
            @(negedge clk_1Mhz);
            case (ready_mode)
                0:       sample_ready_i = 1'b1;
                1:       sample_ready_i = 1'b0;
                default: sample_ready_i = 1'($urandom_range(0, 1));
            endcase
            di_req_i = (req_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // SPI master + pipelined ADC responder: answers each transfer with the
    // result of the previously commanded channel.
    initial begin : spi_model
        int          xfer;
        int          d;
        logic [2:0]  prev_chan;
        logic [15:0] cmd;
        logic [11:0] code;
        logic [3:0]  nib;
        bit          ok;
        bit          abort;
        xfer = 0; prev_chan = 3'd0;
        wr_ack_i = 1'b0; do_valid_i = 1'b0; do_i = 16'h0000;
        push_flag = 1'b0; push_item = 15'h0000;
        forever begin
            @(negedge clk_1Mhz);
            if (reset) begin
                xfer = 0; prev_chan = 3'd0;
            end else if (wren_o === 1'b1) begin
                cmd = di_o; ok = 1'b1; abort = 1'b0;
                d = (rand_mode != 0) ? int'($urandom_range(1, 6)) : ack_dly_fix;
                for (int i = 0; i < d && !abort; i++) begin
                    @(negedge clk_1Mhz);
                    if (reset) abort = 1'b1;
                    else if (di_o !== cmd || wren_o !== 1'b1) ok = 1'b0;
                end
                if (!abort) begin
                    wr_ack_i = 1'b1;
                    cmd_q.push_back(cmd);
                    hold_q.push_back(ok);
                    @(negedge clk_1Mhz);
                    wr_ack_i = 1'b0;
                    if (reset) abort = 1'b1;
                end
                if (!abort) begin
                    d = (rand_mode != 0) ? int'($urandom_range(0, 4)) : data_dly_fix;
                    for (int i = 0; i < d && !abort; i++) begin
                        @(negedge clk_1Mhz);
                        if (reset) abort = 1'b1;
                    end
                end
                if (!abort) begin
                    if (rand_mode != 0) begin
                        code = 12'($urandom);
                        nib  = 4'($urandom);
                    end else begin
                        code = (xfer == 0) ? 12'hFFF : 12'hA00 + 12'(prev_chan);
                        nib  = {1'b0, prev_chan};
                    end
                    do_i       = {nib, code};
                    do_valid_i = 1'b1;
                    push_flag  = (xfer != 0);
                    push_item  = {3'(xfer - 1), code};
                    prev_chan  = cmd[10:8];
                    xfer       = (xfer == N_CHAN) ? 0 : xfer + 1;
                    @(negedge clk_1Mhz);
                    do_valid_i = 1'b0;
                    push_flag  = 1'b0;
                end
                if (abort) begin
                    xfer = 0; prev_chan = 3'd0; wr_ack_i = 1'b0;
                end
            end
        end
    end

    // Sink, frame_done counter and 2-deep buffer model, sampled just before each rising edge
    initial begin : monitor
        bit pop_m;
        forever begin
            @(negedge clk_1Mhz);
            #4;
            if (reset) begin
                model_q.delete();
                exp_ovr = 1'b0;
            end else begin
                if (sample_valid_o !== (model_q.size() != 0)) valid_err++;
                if (sample_valid_o === 1'b1 && sample_ready_i === 1'b1)
                    got_q.push_back({sample_chan_o, sample_data_o});
                if (frame_done_o === 1'b1) done_cnt++;
                pop_m = (model_q.size() != 0) && (sample_ready_i == 1'b1);
                if (pop_m) exp_pop_q.push_back(model_q.pop_front());
                if (push_flag) begin
                    if (model_q.size() < 2) model_q.push_back(push_item);
                    else exp_ovr = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset(input bit en_after);
        @(posedge clk_1Mhz); #2;
        reset = 1'b1; enable_i = 1'b0;
        @(posedge clk_1Mhz); #2;
        cmd_q.delete(); hold_q.delete(); got_q.delete(); exp_pop_q.delete();
        done_cnt = 0; valid_err = 0;
        @(posedge clk_1Mhz); #2;
        reset = 1'b0; enable_i = en_after;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_1Mhz); #2;
            if (done_cnt >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_cmds(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_1Mhz); #2;
            if (cmd_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable_i = 1'b0;
        repeat (3) @(posedge clk_1Mhz);
        #1;
        total_cnt++; if (wren_o !== 1'b0) $display("FAIL reset_wren: got %b want 0", wren_o); else pass_cnt++;
        total_cnt++; if (di_o !== 16'h0000) $display("FAIL reset_di: got %h want 0000", di_o); else pass_cnt++;
        total_cnt++; if (sample_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", sample_valid_o); else pass_cnt++;
        total_cnt++; if (sample_data_o !== 12'h000) $display("FAIL reset_data: got %h want 000", sample_data_o); else pass_cnt++;
        total_cnt++; if (sample_chan_o !== 3'd0) $display("FAIL reset_chan: got %0d want 0", sample_chan_o); else pass_cnt++;
        total_cnt++; if (frame_done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done_o); else pass_cnt++;
        total_cnt++; if (overrun_o !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun_o); else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        logic [15:0] exp_cmd [5];
        logic [14:0] g;
        bit ok;
        exp_cmd = '{16'h1000, 16'h1100, 16'h1200, 16'h1300, 16'h1000};
        ready_mode = 0; req_mode = 0; rand_mode = 0; ack_dly_fix = 2; data_dly_fix = 1;
        do_reset(1'b1);
        wait_frames(1, 400, ok);
        enable_i = 1'b0;
        repeat (10) @(posedge clk_1Mhz);
        #2;
        total_cnt++; if (!ok) $display("FAIL basic_timeout: frame_done count %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (cmd_q.size() != 5) $display("FAIL basic_xfers: got %0d want 5", cmd_q.size()); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            g = (cmd_q.size() > k) ? {cmd_q[k]} [14:0] : 15'h7FFF;
            total_cnt++;
            if (cmd_q.size() <= k || cmd_q[k] !== exp_cmd[k])
                $display("FAIL basic_cmd%0d: got %h want %h", k, (cmd_q.size() > k) ? cmd_q[k] : 16'hxxxx, exp_cmd[k]);
            else pass_cnt++;
        end
        total_cnt++; if (got_q.size() != 4) $display("FAIL basic_samples: got %0d want 4", got_q.size()); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            g = (got_q.size() > k) ? got_q[k] : 15'h7FFF;
            total_cnt++;
            if (g !== {3'(k), 12'hA00 + 12'(k)})
                $display("FAIL basic_sample%0d: got ch%0d %h want ch%0d %h", k, g[14:12], g[11:0], k, 12'hA00 + 12'(k));
            else pass_cnt++;
        end
        total_cnt++; if (done_cnt != 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (overrun_o !== 1'b0) $display("FAIL basic_overrun: got %b want 0", overrun_o); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [14:0] g;
        ready_mode = 1; req_mode = 0; rand_mode = 0; ack_dly_fix = 2; data_dly_fix = 1;
        do_reset(1'b1);
        wait_frames(1, 400, ok);
        enable_i = 1'b0;
        repeat (5) @(posedge clk_1Mhz);
        #2;
        total_cnt++; if (!ok) $display("FAIL bp_timeout: frame_done count %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (got_q.size() != 0) $display("FAIL bp_no_pop: got %0d pops want 0", got_q.size()); else pass_cnt++;
        total_cnt++; if (sample_valid_o !== 1'b1) $display("FAIL bp_valid: got %b want 1", sample_valid_o); else pass_cnt++;
        total_cnt++; if ({sample_chan_o, sample_data_o} !== {3'd0, 12'hA00})
            $display("FAIL bp_head: got ch%0d %h want ch0 a00", sample_chan_o, sample_data_o); else pass_cnt++;
        total_cnt++; if (overrun_o !== 1'b1) $display("FAIL bp_overrun: got %b want 1", overrun_o); else pass_cnt++;
        ready_mode = 0;
        repeat (6) @(posedge clk_1Mhz);
        #2;
        total_cnt++; if (got_q.size() != 2) $display("FAIL bp_drain: got %0d samples want 2", got_q.size()); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            g = (got_q.size() > k) ? got_q[k] : 15'h7FFF;
            total_cnt++;
            if (g !== {3'(k), 12'hA00 + 12'(k)})
                $display("FAIL bp_sample%0d: got ch%0d %h want ch%0d %h", k, g[14:12], g[11:0], k, 12'hA00 + 12'(k));
            else pass_cnt++;
        end
        total_cnt++; if (sample_valid_o !== 1'b0) $display("FAIL bp_empty: got %b want 0", sample_valid_o); else pass_cnt++;
        total_cnt++; if (overrun_o !== 1'b1) $display("FAIL bp_sticky: got %b want 1", overrun_o); else pass_cnt++;
    endtask

    task automatic test_enable_drop();
        bit ok1, ok2;
        ready_mode = 0; req_mode = 0; rand_mode = 0; ack_dly_fix = 2; data_dly_fix = 1;
        do_reset(1'b1);
        wait_cmds(2, 200, ok1);
        enable_i = 1'b0;
        wait_frames(1, 400, ok2);
        repeat (600) @(posedge clk_1Mhz);
        #2;
        total_cnt++; if (!(ok1 && ok2)) $display("FAIL endrop_timeout: cmds %0d frames %0d", cmd_q.size(), done_cnt); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL endrop_frames: got %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (cmd_q.size() != 5) $display("FAIL endrop_xfers: got %0d want 5", cmd_q.size()); else pass_cnt++;
        total_cnt++; if (got_q.size() != 4) $display("FAIL endrop_samples: got %0d want 4", got_q.size()); else pass_cnt++;
        total_cnt++; if (wren_o !== 1'b0) $display("FAIL endrop_wren: got %b want 0", wren_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [14:0] g;
        ready_mode = 0; req_mode = 0; rand_mode = 0; ack_dly_fix = 2; data_dly_fix = 4;
        do_reset(1'b1);
        wait_cmds(3, 200, ok);
        total_cnt++; if (!ok) $display("FAIL midrst_timeout: cmds %0d want 3", cmd_q.size()); else pass_cnt++;
        reset = 1'b1;
        @(posedge clk_1Mhz); #1;
        total_cnt++; if ({wren_o, di_o} !== 17'h0_0000) $display("FAIL midrst_spi: got wren %b di %h want 0 0000", wren_o, di_o); else pass_cnt++;
        total_cnt++; if ({sample_valid_o, sample_chan_o, sample_data_o} !== 16'h0000)
            $display("FAIL midrst_sample: got v%b ch%0d %h want 0", sample_valid_o, sample_chan_o, sample_data_o); else pass_cnt++;
        total_cnt++; if ({frame_done_o, overrun_o} !== 2'b00) $display("FAIL midrst_flags: got %b%b want 00", frame_done_o, overrun_o); else pass_cnt++;
        do_reset(1'b1);
        wait_frames(1, 400, ok);
        enable_i = 1'b0;
        repeat (5) @(posedge clk_1Mhz);
        #2;
        g = (got_q.size() > 0) ? got_q[0] : 15'h7FFF;
        total_cnt++; if (g !== {3'd0, 12'hA00}) $display("FAIL midrst_first: got ch%0d %h want ch0 a00", g[14:12], g[11:0]); else pass_cnt++;
        total_cnt++; if (got_q.size() != 4) $display("FAIL midrst_count: got %0d want 4", got_q.size()); else pass_cnt++;
    endtask

    task automatic test_slow_ack();
        bit ok;
        int bad;
        ready_mode = 0; req_mode = 0; rand_mode = 0; ack_dly_fix = 10; data_dly_fix = 2;
        do_reset(1'b1);
        wait_frames(1, 500, ok);
        enable_i = 1'b0;
        repeat (5) @(posedge clk_1Mhz);
        #2;
        bad = 0;
        foreach (hold_q[i]) if (!hold_q[i]) bad++;
        total_cnt++; if (!ok) $display("FAIL slow_timeout: frames %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL slow_hold: %0d transfers changed wren/di before ack, want 0", bad); else pass_cnt++;
        total_cnt++; if (cmd_q.size() != 5) $display("FAIL slow_xfers: got %0d want 5", cmd_q.size()); else pass_cnt++;
        total_cnt++; if (got_q.size() != 4) $display("FAIL slow_samples: got %0d want 4", got_q.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad_cmd, bad_hold, bad_smp;
        int ch;
        ready_mode = 2; req_mode = 1; rand_mode = 1;
        do_reset(1'b1);
        wait_frames(6, 2000, ok);
        enable_i = 1'b0;
        ready_mode = 0;
        repeat (30) @(posedge clk_1Mhz);
        #2;
        bad_cmd = 0; bad_hold = 0; bad_smp = 0;
        foreach (cmd_q[k]) begin
            ch = ((k % (N_CHAN + 1)) < N_CHAN) ? (k % (N_CHAN + 1)) : 0;
            if (cmd_q[k] !== {4'h1, 1'b0, 3'(ch), 8'h00}) bad_cmd++;
        end
        foreach (hold_q[k]) if (!hold_q[k]) bad_hold++;
        foreach (exp_pop_q[k]) if (got_q.size() <= k || got_q[k] !== exp_pop_q[k]) bad_smp++;
        total_cnt++; if (!ok || done_cnt != 6) $display("FAIL rand_frames: got %0d want 6", done_cnt); else pass_cnt++;
        total_cnt++; if (cmd_q.size() != 6 * (N_CHAN + 1)) $display("FAIL rand_xfers: got %0d want %0d", cmd_q.size(), 6 * (N_CHAN + 1)); else pass_cnt++;
        total_cnt++; if (bad_cmd != 0) $display("FAIL rand_cmds: %0d wrong command words, want 0", bad_cmd); else pass_cnt++;
        total_cnt++; if (bad_hold != 0) $display("FAIL rand_hold: %0d unstable transfers, want 0", bad_hold); else pass_cnt++;
        total_cnt++; if (got_q.size() != exp_pop_q.size()) $display("FAIL rand_count: got %0d samples want %0d", got_q.size(), exp_pop_q.size()); else pass_cnt++;
        total_cnt++; if (bad_smp != 0) $display("FAIL rand_samples: %0d sample mismatches, want 0", bad_smp); else pass_cnt++;
        total_cnt++; if (overrun_o !== exp_ovr) $display("FAIL rand_overrun: got %b want %b", overrun_o, exp_ovr); else pass_cnt++;
        total_cnt++; if (valid_err != 0) $display("FAIL rand_valid: %0d cycles sample_valid_o disagreed with occupancy, want 0", valid_err); else pass_cnt++;
    endtask

    initial begin : main
        done_cnt = 0; valid_err = 0; exp_ovr = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_enable_drop();
        test_reset_mid_frame();
        test_slow_ack();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/adc_frame_sequencer.md
ADC_FRAME_SEQUENCER -- requirements
Module: adc_frame_sequencer

Interface
REQ-001 Parameter N_CHAN, default 4: channels converted per frame, 1..8.
REQ-002 Parameter FRAME_DIV, default 250: clk_1Mhz cycles between frame starts, minimum 64.
REQ-003 Parameter CMD_PREFIX, default 4'h1: upper nibble of every ADC command word.
REQ-004 clk_1Mhz  in  1: sole clock, identical to the spi_master sclk_i.
REQ-005 reset  in  1: synchronous, active-high.
REQ-006 enable_i  in  1: level; 1 runs periodic frames.
REQ-007 di_req_i  in  1: spi_master requests the next transmit word.
REQ-008 di_o  out  16: command word to spi_master di_i.
REQ-009 wren_o  out  1: write strobe to spi_master wren_i.
REQ-010 wr_ack_i  in  1: spi_master accepted di_o.
REQ-011 do_valid_i  in  1: single-cycle pulse, received word valid.
REQ-012 do_i  in  16: received word, {chan[3:0], code[11:0]}.
REQ-013 sample_valid_o / sample_ready_i  out/in  1/1: downstream valid/ready handshake.
REQ-014 sample_data_o  out  12: conversion code.
REQ-015 sample_chan_o  out  3: channel index of sample_data_o.
REQ-016 frame_done_o  out  1: one-cycle pulse after the last sample of a frame is buffered.
REQ-017 overrun_o  out  1: sticky, a sample was dropped.

Function
REQ-018 A free-running frame counter SHALL count 0..FRAME_DIV-1 and wrap; tick at count 0 starts a frame only while enable_i=1 and the FSM is IDLE.
REQ-019 FSM states: IDLE, LOAD, WAIT_ACK, WAIT_DATA, DONE.
REQ-020 IDLE->LOAD on tick; LOAD drives di_o and asserts wren_o when di_req_i=1; LOAD->WAIT_ACK same cycle.
REQ-021 wren_o SHALL stay high, di_o stable, until wr_ack_i=1; then WAIT_ACK->WAIT_DATA.
REQ-022 WAIT_DATA->LOAD on do_valid_i while transfers remain; ->DONE after the last do_valid_i.
REQ-023 Each frame SHALL issue N_CHAN+1 transfers; transfer k (0..N_CHAN-1) commands channel k, transfer N_CHAN repeats channel 0 as dummy.
REQ-024 Command word = {CMD_PREFIX, 1'b0, chan[2:0], 8'h00}.
REQ-025 The ADC is pipelined: word received on transfer 0 SHALL be discarded; word received on transfer k (k>=1) is the result for channel k-1.
REQ-026 sample_chan_o SHALL come from the sequencer channel counter, not do_i[15:12]; a mismatch between them SHALL still be accepted.
REQ-027 Samples SHALL pass through a 2-entry FIFO; sample_valid_o = FIFO non-empty; pop on valid&ready.
REQ-028 Result arriving with FIFO full and no pop that cycle SHALL be dropped and set overrun_o; simultaneous push and pop on a full FIFO SHALL succeed.
REQ-029 DONE pulses frame_done_o for one cycle and returns to IDLE.
REQ-030 Deasserting enable_i mid-frame SHALL let the current frame complete; no new frame starts.
REQ-031 A tick arriving while not IDLE SHALL be ignored; no frame is queued.
REQ-032 do_valid_i outside WAIT_DATA SHALL be ignored.

Reset
REQ-033 On reset: FSM IDLE, frame counter 0, channel/transfer counters 0, FIFO empty, wren_o=0, di_o=16'h0, sample_valid_o=0, sample_data_o=0, sample_chan_o=0, frame_done_o=0, overrun_o=0.
REQ-034 Reset mid-frame SHALL abort immediately; no partial sample is emitted.
REQ-035 overrun_o clears only on reset.

Structure
REQ-036 Shared package holds FSM state encoding, CMD word field positions, and the 12-bit code width.
REQ-037 The 2-entry FIFO SHALL be sub-module adc_sample_fifo.

Verification
REQ-038 N_CHAN=4, enable=1, spi model acks after 2 cycles, returns {chan,12'hA00+chan} -> samples ch0..3 codes 12'hA00..12'hA03 in order, one frame_done_o pulse, 5 transfers.
REQ-039 Commands observed on di_o for one frame -> 16'h1000,1100,1200,1300,1000.
REQ-040 sample_ready_i=0 whole frame -> 2 samples buffered (ch0, ch1), overrun_o=1, sample_valid_o stays 1.
REQ-041 enable_i dropped after 2nd transfer -> frame completes with 4 samples, no further tick starts a frame.
REQ-042 reset asserted during WAIT_DATA of transfer 2 -> all outputs at reset values next cycle, first sample after re-enable is ch0.
REQ-043 wr_ack_i delayed 10 cycles -> wren_o and di_o held constant throughout, no duplicate transfer.
